// File: rtl/computation_pkg.sv
// Shared definitions for the 128-bit operand link (slave and master-side transceiver).
package computation_pkg;

  // Framing FSM states of the slave
  typedef enum logic [1:0] {
    RECV = 2'd0,
    MUL  = 2'd1,
    SEND = 2'd2
  } state_t;

  // Link byte width and default operand width
  localparam int BYTE_W    = 8;
  localparam int OPERAND_W = 64;

  // Bytes per frame in each direction: {param1, param2} inbound, product outbound
  localparam int FRAME_BYTES = 2 * OPERAND_W / BYTE_W;

  // Byte 0 of every frame carries the most significant byte of the frame
  localparam bit MSB_FIRST = 1'b1;

  // Bit position of the least significant bit of byte idx in an n_bytes frame
  function automatic int frame_byte_lsb(input int idx, input int n_bytes);
    return (n_bytes - 1 - idx) * BYTE_W;
  endfunction

endpackage

// File: rtl/seq_mult_shift_add.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per clock, fixed DATA_W-cycle latency.
module seq_mult_shift_add
  import computation_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   p
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [2*DATA_W-1:0] acc_q;
  logic [2*DATA_W-1:0] mcand_q;
  logic [DATA_W-1:0]   mplier_q;
  logic [CNT_W-1:0]    bits_left_q;
  logic                running_q;
  logic                done_q;

  // Start handles bit 0 of b directly so the whole product takes exactly DATA_W cycles;
  // the remaining DATA_W-1 bits are consumed one per cycle, done pulses after the last one.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      bits_left_q <= '0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q       <= b[0] ? {{DATA_W{1'b0}}, a} : '0;
        mcand_q     <= {{(DATA_W-1){1'b0}}, a, 1'b0};
        mplier_q    <= b >> 1;
        bits_left_q <= CNT_W'(DATA_W - 1);
        running_q   <= 1'b1;
      end else if (running_q) begin
        if (mplier_q[0]) begin
          acc_q <= acc_q + mcand_q;
        end
        mcand_q     <= mcand_q << 1;
        mplier_q    <= mplier_q >> 1;
        bits_left_q <= bits_left_q - CNT_W'(1);
        if (bits_left_q == CNT_W'(1)) begin
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign done = done_q;
  assign p    = acc_q;

endmodule

// File: rtl/computation_slave.sv
// Far end of the operand link: receives {param1, param2} byte frames, multiplies, returns the product.
module computation_slave
  import computation_pkg::*;
#(
  parameter int DATA_W      = 64,
  parameter int GAP_TIMEOUT = 50000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [7:0]   rx_byte,
  input  logic         rx_valid,
  output logic [7:0]   tx_byte,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         frame_done,
  output logic         overrun,
  output logic         timeout
);

  localparam int FRAME_N    = 2 * DATA_W / BYTE_W;
  localparam int FRAME_BITS = 2 * DATA_W;
  localparam int CNT_W      = $clog2(FRAME_N);
  localparam int GAP_W      = $clog2(GAP_TIMEOUT + 1);

  state_t                state_q;
  state_t                state_d;
  logic [CNT_W-1:0]      rx_cnt_q;
  logic [CNT_W-1:0]      tx_cnt_q;
  logic [GAP_W-1:0]      gap_q;
  logic [FRAME_BITS-1:0] frame_q;
  logic [FRAME_BITS-1:0] product_q;
  logic                  start_q;
  logic                  hold_q;
  logic                  mult_done;
  logic [FRAME_BITS-1:0] mult_p;
  logic                  gap_expired;
  logic                  tx_fire;
  logic                  rx_last;
  logic                  tx_last;

  // A partial frame expires once the idle gap reaches the limit; an empty frame never expires
  assign gap_expired = (state_q == RECV) && (rx_cnt_q != '0) && (gap_q == GAP_W'(GAP_TIMEOUT));
  assign rx_last     = (rx_cnt_q == CNT_W'(FRAME_N - 1));
  assign tx_last     = (tx_cnt_q == CNT_W'(FRAME_N - 1));

  // A byte is only issued while the transmitter is idle and the post-byte hold cycle is over
  assign tx_fire = (state_q == SEND) && tx_ready && !hold_q;
  assign tx_byte = tx_fire ? product_q[FRAME_BITS-1 -: BYTE_W] : '0;

  seq_mult_shift_add #(
    .DATA_W (DATA_W)
  ) u_mult (
    .clock (clock),
    .reset (reset),
    .start (start_q),
    .a     (frame_q[FRAME_BITS-1 -: DATA_W]),
    .b     (frame_q[DATA_W-1:0]),
    .done  (mult_done),
    .p     (mult_p)
  );

  // State register; a reset at any point abandons the current frame
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and the status strobes that depend on the current state
  always_comb begin
    state_d    = state_q;
    tx_valid   = 1'b0;
    frame_done = 1'b0;
    overrun    = 1'b0;
    timeout    = 1'b0;
    busy       = (state_q != RECV);
    case (state_q)
      RECV: begin
        timeout = gap_expired;
        if (rx_valid && !gap_expired && rx_last) begin
          state_d = MUL;
        end
      end
      MUL: begin
        overrun = rx_valid;
        if (mult_done) begin
          state_d = SEND;
        end
      end
      SEND: begin
        overrun  = rx_valid;
        tx_valid = tx_fire;
        if (tx_fire && tx_last) begin
          frame_done = 1'b1;
          state_d    = RECV;
        end
      end
      default: begin
        state_d = RECV;
      end
    endcase
  end

  // Datapath: inbound shift register with gap timer, multiplier kick-off, outbound shift register
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      gap_q     <= '0;
      frame_q   <= '0;
      product_q <= '0;
      start_q   <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        RECV: begin
          if (rx_valid) begin
            frame_q <= {frame_q[FRAME_BITS-BYTE_W-1:0], rx_byte};
            gap_q   <= '0;
            if (gap_expired) begin
              rx_cnt_q <= CNT_W'(1);
            end else if (rx_last) begin
              rx_cnt_q <= '0;
              start_q  <= 1'b1;
            end else begin
              rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
          end else if (gap_expired) begin
            rx_cnt_q <= '0;
            gap_q    <= '0;
          end else if (rx_cnt_q != '0) begin
            gap_q <= gap_q + GAP_W'(1);
          end else begin
            gap_q <= '0;
          end
        end
        MUL: begin
          if (mult_done) begin
            product_q <= mult_p;
            tx_cnt_q  <= '0;
            hold_q    <= 1'b0;
          end
        end
        SEND: begin
          hold_q <= tx_fire;
          if (tx_fire) begin
            product_q <= product_q << BYTE_W;
            tx_cnt_q  <= tx_last ? '0 : tx_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          hold_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
